// File: rtl/matrix_op_elementwise.sv
// matrix_op_elementwise
//   Element-wise matrix engine: A*s, A+B, A-B or A+s over a dim_m x dim_n
//   row-major unsigned matrix held in a shared single-read/single-write BRAM.
//   Each element is read (A, then B for binary modes), combined, optionally
//   clamped, and written to the result area. sat_flag is sticky per operation.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         level request, sampled only in IDLE
//   mode, dim_m, dim_n            operation select and matrix shape
//   addr_op1, addr_op2, addr_res  base addresses (modulo 2^ADDR_WIDTH)
//   scalar_val                    scalar operand for modes 0 and 3
//   busy, done, error, sat_flag   status (error valid while done is high)
//   mem_rd_*, mem_wr_*            BRAM ports, read latency of one cycle
module matrix_op_elementwise #(
    parameter int ELEMENT_WIDTH = 16,
    parameter int ADDR_WIDTH    = 9,
    parameter int DIM_WIDTH     = 5,
    parameter int MAX_DIM       = 16,
    parameter int SCALAR_WIDTH  = 8,
    parameter int SATURATE      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [DIM_WIDTH-1:0]     dim_m,
    input  logic [DIM_WIDTH-1:0]     dim_n,
    input  logic [ADDR_WIDTH-1:0]    addr_op1,
    input  logic [ADDR_WIDTH-1:0]    addr_op2,
    input  logic [SCALAR_WIDTH-1:0]  scalar_val,
    input  logic [ADDR_WIDTH-1:0]    addr_res,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     sat_flag,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data
);
    localparam int W  = ELEMENT_WIDTH;
    localparam int SW = SCALAR_WIDTH;
    localparam int IW = 2 * DIM_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_WAIT, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [DIM_WIDTH-1:0]  dim_m_q, dim_m_d, dim_n_q, dim_n_d;
    logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic [SW-1:0]         scalar_q, scalar_d;
    logic [W-1:0]          a_q, a_d;
    logic                  sat_q, sat_d, err_q, err_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [W-1:0]          wr_data_q, wr_data_d;

    logic                  binary_s, last_s, ovf_s, udf_s;
    logic [W-1:0]          opa_s, opb_s, result_s;
    logic [W+SW-1:0]       prod_s;
    logic [W:0]            sum_s, add_s;

    // Element arithmetic, next-state logic and next values of all registered outputs
    always_comb begin
        binary_s  = (mode_q == 2'd1) || (mode_q == 2'd2);
        // In binary modes A was parked in a_q during RD_B; B (or unary A) arrives now.
        opa_s     = binary_s ? a_q : mem_rd_data;
        opb_s     = mem_rd_data;
        prod_s    = {{SW{1'b0}}, opa_s} * {{W{1'b0}}, scalar_q};
        sum_s     = {1'b0, opa_s} + {1'b0, opb_s};
        add_s     = {1'b0, opa_s} + (W+1)'(scalar_q);
        ovf_s     = 1'b0;
        udf_s     = 1'b0;
        result_s  = '0;
        case (mode_q)
            2'd0: begin ovf_s = |prod_s[W+SW-1:W]; result_s = prod_s[W-1:0]; end
            2'd1: begin ovf_s = sum_s[W];          result_s = sum_s[W-1:0];  end
            2'd2: begin udf_s = opa_s < opb_s;     result_s = opa_s - opb_s; end
            2'd3: begin ovf_s = add_s[W];          result_s = add_s[W-1:0];  end
            default: result_s = '0;
        endcase
        if (ovf_s && (SATURATE != 0)) begin
            result_s = '1;
        end else if (udf_s && (SATURATE != 0)) begin
            result_s = '0;
        end else begin
            result_s = result_s;
        end

        last_s = (row_q == dim_m_q - DIM_WIDTH'(1)) && (col_q == dim_n_q - DIM_WIDTH'(1));

        state_d   = state_q;
        mode_d    = mode_q;
        dim_m_d   = dim_m_q;
        dim_n_d   = dim_n_q;
        row_d     = row_q;
        col_d     = col_q;
        idx_d     = idx_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        res_d     = res_q;
        scalar_d  = scalar_q;
        a_d       = a_q;
        sat_d     = sat_q;
        err_d     = err_q;
        wr_data_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    dim_m_d  = dim_m;
                    dim_n_d  = dim_n;
                    op1_d    = addr_op1;
                    op2_d    = addr_op2;
                    res_d    = addr_res;
                    scalar_d = scalar_val;
                    row_d    = '0;
                    col_d    = '0;
                    idx_d    = '0;
                    sat_d    = 1'b0;
                    if ((dim_m == '0) || (dim_n == '0) ||
                        (int'(dim_m) > MAX_DIM) || (int'(dim_n) > MAX_DIM)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RD_A;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_A:  state_d = binary_s ? S_RD_B : S_WAIT;
            S_RD_B: begin
                a_d     = mem_rd_data;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wr_data_d = result_s;
                sat_d     = sat_q | ovf_s | udf_s;
                state_d   = S_WRITE;
            end
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_RD_A;
                    if (col_q == dim_n_q - DIM_WIDTH'(1)) begin
                        col_d = '0;
                        row_d = row_q + DIM_WIDTH'(1);
                    end else begin
                        col_d = col_q + DIM_WIDTH'(1);
                    end
                end
            end
            S_DONE:  state_d = start ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        busy_d    = (state_d == S_RD_A) || (state_d == S_RD_B) || (state_d == S_WAIT) ||
                    (state_d == S_WRITE) || (state_d == S_NEXT);
        done_d    = (state_d == S_DONE);
        rd_en_d   = (state_d == S_RD_A) || (state_d == S_RD_B);
        wr_en_d   = (state_d == S_WRITE);
        if (state_d == S_RD_A) begin
            rd_addr_d = op1_d + ADDR_WIDTH'(idx_d);
        end else if (state_d == S_RD_B) begin
            rd_addr_d = op2_d + ADDR_WIDTH'(idx_d);
        end else begin
            rd_addr_d = '0;
        end
        wr_addr_d = wr_en_d ? (res_d + ADDR_WIDTH'(idx_d)) : '0;
    end

    // State, operand latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            dim_m_q   <= '0;
            dim_n_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            idx_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            res_q     <= '0;
            scalar_q  <= '0;
            a_q       <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dim_m_q   <= dim_m_d;
            dim_n_q   <= dim_n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            idx_q     <= idx_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            res_q     <= res_d;
            scalar_q  <= scalar_d;
            a_q       <= a_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign sat_flag    = sat_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_matrix_op_elementwise.sv
// Bench for matrix_op_elementwise: a saturating (index 0) and a wrapping
// (index 1) instance run the same operations on private memories, and are
// compared against a sequential element-by-element reference model.
module tb_matrix_op_elementwise;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] mode;
    logic [4:0] dim_m, dim_n;
    logic [8:0] addr_op1, addr_op2, addr_res;
    logic [7:0] scalar_val;

    logic        busy_v [2], done_v [2], err_v [2], sat_v [2], rd_en_v [2], wr_en_v [2];
    logic [8:0]  rd_addr_v [2], wr_addr_v [2];
    logic [15:0] rd_data_v [2], wr_data_v [2];

    logic [15:0] mem [2][512];
    logic [15:0] preload [512];
    int          exp_mem [2][512];
    logic        load = 1'b0;

    int rd_cnt [2], wr_cnt [2], viol [2];
    logic prev_rd [2], prev_wr [2];
    int n_checks = 0, n_fail = 0;

    typedef struct {
        int mode, m, n, op1, op2, res, s, pat, exp_done, exp_err, exp_sat, hold;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    matrix_op_elementwise #(.SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dim_m(dim_m), .dim_n(dim_n),
        .addr_op1(addr_op1), .addr_op2(addr_op2), .scalar_val(scalar_val), .addr_res(addr_res),
        .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]), .sat_flag(sat_v[0]),
        .mem_rd_en(rd_en_v[0]), .mem_rd_addr(rd_addr_v[0]), .mem_rd_data(rd_data_v[0]),
        .mem_wr_en(wr_en_v[0]), .mem_wr_addr(wr_addr_v[0]), .mem_wr_data(wr_data_v[0]));

    matrix_op_elementwise #(.SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dim_m(dim_m), .dim_n(dim_n),
        .addr_op1(addr_op1), .addr_op2(addr_op2), .scalar_val(scalar_val), .addr_res(addr_res),
        .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]), .sat_flag(sat_v[1]),
        .mem_rd_en(rd_en_v[1]), .mem_rd_addr(rd_addr_v[1]), .mem_rd_data(rd_data_v[1]),
        .mem_wr_en(wr_en_v[1]), .mem_wr_addr(wr_addr_v[1]), .mem_wr_data(wr_data_v[1]));

    // BRAM models with one cycle read latency, plus bulk preload
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (load) begin
                for (int a = 0; a < 512; a++) mem[u][a] <= preload[a];
            end else if (wr_en_v[u]) begin
                mem[u][wr_addr_v[u]] <= wr_data_v[u];
            end
            if (rd_en_v[u]) rd_data_v[u] <= mem[u][rd_addr_v[u]];
        end
    end

    // Strobe counters and one-cycle-width / read-write exclusion monitor
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                prev_rd[u] <= 1'b0;
                prev_wr[u] <= 1'b0;
            end else begin
                if (rd_en_v[u]) rd_cnt[u] <= rd_cnt[u] + 1;
                if (wr_en_v[u]) wr_cnt[u] <= wr_cnt[u] + 1;
                if ((rd_en_v[u] && wr_en_v[u]) || (wr_en_v[u] && prev_wr[u]))
                    viol[u] <= viol[u] + 1;
                prev_rd[u] <= rd_en_v[u];
                prev_wr[u] <= wr_en_v[u];
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int md, int m, int n, int op1, int op2, int res, int s,
                                int pat, int ed, int ee, int es, int hold);
        vec_t v;
        v.mode = md; v.m = m; v.n = n; v.op1 = op1; v.op2 = op2; v.res = res; v.s = s;
        v.pat = pat; v.exp_done = ed; v.exp_err = ee; v.exp_sat = es; v.hold = hold;
        return v;
    endfunction

    // Reference arithmetic straight from the mode definitions, in plain integers.
    task automatic model_elem(input int md, input int a, input int b, input int s,
                              input bit sat, output int r, output bit flag);
        int full;
        flag = 1'b0;
        case (md)
            0: full = a * s;
            1: full = a + b;
            2: full = a - b;
            default: full = a + s;
        endcase
        if (full > 65535) begin
            flag = 1'b1;
            r = sat ? 65535 : full % 65536;
        end else if (full < 0) begin
            flag = 1'b1;
            r = sat ? 0 : full + 65536;
        end else begin
            r = full;
        end
    endtask

    task automatic prepare(input vec_t v, output int msat);
        int r, nn;
        bit f, any;
        for (int a = 0; a < 512; a++) preload[a] = 16'($urandom_range(0, 59999));
        case (v.pat)
            0: for (int i = 0; i < 6; i++) preload[(v.op1 + i) % 512] = 16'(i + 1);
            1: for (int i = 0; i < 16; i++) begin
                   preload[(v.op1 + i) % 512] = 16'hFFF0;
                   preload[(v.op2 + i) % 512] = 16'h0020;
               end
            2: begin
                   preload[v.op1] = 16'd5; preload[(v.op1 + 1) % 512] = 16'd2;
                   preload[v.op2] = 16'd3; preload[(v.op2 + 1) % 512] = 16'd7;
               end
            5: preload[v.op1] = 16'h0200;
            default: ;
        endcase
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        msat = 0;
        nn = (v.m < 1 || v.n < 1 || v.m > 16 || v.n > 16) ? 0 : v.m * v.n;
        for (int u = 0; u < 2; u++) begin
            any = 1'b0;
            for (int a = 0; a < 512; a++) exp_mem[u][a] = preload[a];
            for (int k = 0; k < nn; k++) begin
                model_elem(v.mode, exp_mem[u][(v.op1 + k) % 512], exp_mem[u][(v.op2 + k) % 512],
                           v.s, (u == 0), r, f);
                exp_mem[u][(v.res + k) % 512] = r;
                any |= f;
            end
            if (u == 0) msat = any;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int msat, esat, nn, erd, c, done_cyc, r0 [2], w0 [2], bad;
        prepare(v, msat);
        esat = (v.exp_sat >= 0) ? v.exp_sat : msat;
        nn   = v.exp_err ? 0 : v.m * v.n;
        erd  = (v.mode == 1 || v.mode == 2) ? 2 * nn : nn;
        @(negedge clk);
        mode = 2'(v.mode); dim_m = 5'(v.m); dim_n = 5'(v.n);
        addr_op1 = 9'(v.op1); addr_op2 = 9'(v.op2); addr_res = 9'(v.res);
        scalar_val = 8'(v.s); start = 1'b1;
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin r0[u] = rd_cnt[u]; w0[u] = wr_cnt[u]; end
        #1;
        // Inputs changed after acceptance must be ignored.
        mode = 2'($urandom); dim_m = 5'($urandom); dim_n = 5'($urandom);
        addr_op1 = 9'($urandom); addr_op2 = 9'($urandom); addr_res = 9'($urandom);
        scalar_val = 8'($urandom);
        c = 0; done_cyc = -1;
        while (done_cyc < 0 && c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check({tag, "_busy_c1"}, busy_v[0], !v.exp_err);
                check({tag, "_rd_c1"}, rd_en_v[0], !v.exp_err);
            end
            if (done_v[0]) done_cyc = c;
        end
        check({tag, "_done_cycle"}, done_cyc, v.exp_done);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s_done_%0d", tag, u), done_v[u], 1);
            check($sformatf("%s_busy_%0d", tag, u), busy_v[u], 0);
            check($sformatf("%s_error_%0d", tag, u), err_v[u], v.exp_err);
            check($sformatf("%s_sat_%0d", tag, u), sat_v[u], esat);
        end
        if (v.hold > 0) begin
            repeat (v.hold) @(negedge clk);
            check({tag, "_done_held"}, done_v[0], 1);
        end
        start = 1'b0;
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s_reads_%0d", tag, u), rd_cnt[u] - r0[u], erd);
            check($sformatf("%s_writes_%0d", tag, u), wr_cnt[u] - w0[u], nn);
        end
        @(negedge clk);
        check({tag, "_done_low"}, done_v[0], 0);
        for (int u = 0; u < 2; u++) begin
            bad = 0;
            for (int a = 0; a < 512; a++) if (int'(mem[u][a]) != exp_mem[u][a]) bad++;
            check($sformatf("%s_mem_bad_words_%0d", tag, u), bad, 0);
        end
    endtask

    initial begin
        vec_t rv;
        int c, r0, w0;
        for (int u = 0; u < 2; u++) begin
            rd_cnt[u] = 0; wr_cnt[u] = 0; viol[u] = 0;
            rd_data_v[u] = 16'd0;
        end
        rst = 1'b1; start = 1'b0; mode = 2'd0; dim_m = 5'd0; dim_n = 5'd0;
        addr_op1 = 9'd0; addr_op2 = 9'd0; addr_res = 9'd0; scalar_val = 8'd0;
        tbl[0] = mk(0, 2, 3, 10, 0, 100, 3, 0, 25, 0, 0, 0);
        tbl[1] = mk(1, 4, 4, 64, 128, 192, 0, 1, 81, 0, 1, 0);
        tbl[2] = mk(2, 1, 2, 200, 210, 220, 0, 2, 11, 0, 1, 0);
        tbl[3] = mk(0, 0, 3, 5, 6, 7, 4, 3, 1, 1, 0, 0);
        tbl[4] = mk(1, 2, 17, 5, 6, 7, 4, 3, 1, 1, 0, 0);
        tbl[5] = mk(3, 16, 16, 500, 7, 500, 9, 3, 1025, 0, 0, 0);
        tbl[6] = mk(0, 1, 1, 3, 9, 4, 255, 5, 5, 0, 1, 8);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++)
            check($sformatf("reset_outputs_%0d", u),
                  {busy_v[u], done_v[u], err_v[u], sat_v[u], rd_en_v[u], wr_en_v[u],
                   rd_addr_v[u], wr_addr_v[u], wr_data_v[u]}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) for (int k = 0; k < 6; k++)
                check($sformatf("vec0_res%0d", k), mem[0][100 + k], 3 * (k + 1));
            if (i == 1) begin
                check("vec1_sat_val", mem[0][192], 16'hFFFF);
                check("vec1_wrap_val", mem[1][192], 16'h0010);
            end
            if (i == 2) begin
                check("vec2_res0", mem[0][220], 2);
                check("vec2_res1_sat", mem[0][221], 0);
                check("vec2_res1_wrap", mem[1][221], 16'hFFFB);
            end
            if (i == 5) check("vec5_wrap_last", mem[0][243], preload[243] + 16'd9);
            if (i == 6) check("vec6_wrap_val", mem[1][4], 16'hFE00);
        end

        // Reset in the middle of a binary run.
        rv = mk(1, 2, 2, 20, 40, 60, 0, 3, 21, 0, -1, 0);
        @(negedge clk);
        mode = 2'd1; dim_m = 5'd2; dim_n = 5'd2; addr_op1 = 9'd20; addr_op2 = 9'd40;
        addr_res = 9'd60; scalar_val = 8'd0; start = 1'b1;
        @(posedge clk);
        c = 0;
        while (c < 7) begin @(negedge clk); c++; end
        rst = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++)
            check($sformatf("midrst_strobes_%0d", u),
                  {rd_en_v[u], wr_en_v[u], busy_v[u], done_v[u]}, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        r0 = rd_cnt[0]; w0 = wr_cnt[0];
        repeat (4) @(posedge clk);
        check("midrst_quiet", (rd_cnt[0] - r0) + (wr_cnt[0] - w0), 0);
        apply_vec(rv, "after_rst");

        // Randomised operations against the model.
        for (int i = 0; i < 8; i++) begin
            rv = mk($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(1, 4),
                    $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511),
                    $urandom_range(0, 255), 3, 0, 0, -1, 0);
            rv.exp_done = ((rv.mode == 1 || rv.mode == 2) ? 5 : 4) * rv.m * rv.n + 1;
            apply_vec(rv, $sformatf("rand%0d", i));
        end

        for (int u = 0; u < 2; u++)
            check($sformatf("strobe_violations_%0d", u), viol[u], 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_op_elementwise.md
# matrix_op_elementwise

Parametrised element-wise matrix engine; generalises the scalar-multiply operator to four modes: scalar multiply, matrix add, matrix subtract and scalar add. Optional saturation and a sticky overflow flag are included. It sits beside the other matrix operator blocks behind the top-level controller and shares the single-port-read/single-port-write matrix BRAM interface. Operands and results are row-major, unsigned, and stored at base addresses supplied at start.

## Interface
Parameters:
- ELEMENT_WIDTH, 16: element width in bits (unsigned).
- ADDR_WIDTH, 9: BRAM address width.
- DIM_WIDTH, 5: width of dim_m/dim_n.
- MAX_DIM, 16: largest legal dimension.
- SCALAR_WIDTH, 8: scalar width (unsigned).
- SATURATE, 1: 1 = clamp on overflow/underflow, 0 = wrap (truncate).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled only in IDLE.
- mode  in  2  operation select: 0 = A*s, 1 = A+B, 2 = A-B, 3 = A+s.
- dim_m, dim_n  in  DIM_WIDTH  rows, columns.
- addr_op1, addr_op2  in  ADDR_WIDTH  base addresses of A and B; addr_op2 is ignored in modes 0 and 3.
- scalar_val  in  SCALAR_WIDTH  scalar s.
- addr_res  in  ADDR_WIDTH  result base address.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  completion level.
- error  out  1  illegal dimension; valid while done is high.
- sat_flag  out  1  sticky: at least one element overflowed or underflowed during this operation.
- mem_rd_en  out  1; mem_rd_addr  out  ADDR_WIDTH; mem_rd_data  in  ELEMENT_WIDTH.
- mem_wr_en  out  1; mem_wr_addr  out  ADDR_WIDTH; mem_wr_data  out  ELEMENT_WIDTH.

## Operation
- States: IDLE, RD_A, RD_B, WAIT, WRITE, NEXT, DONE.
- IDLE with start=1:
  - Latch mode, dims, addresses and scalar into internal registers. Later input changes are ignored until the next IDLE.
  - Clear sat_flag and error.
  - If dim_m or dim_n is 0 or greater than MAX_DIM: go to DONE with error=1 and perform no memory access.
  - Otherwise go to RD_A.
- Element index idx runs linearly from 0 to dim_m*dim_n-1. No i*n+j multiply is used.
- Addresses are base+idx, computed modulo 2^ADDR_WIDTH (wrap-around allowed, not flagged).
- RD_A: mem_rd_en=1, mem_rd_addr=addr_op1+idx. Next state is RD_B in modes 1/2, WAIT otherwise.
- RD_B: mem_rd_en=1, mem_rd_addr=addr_op2+idx. mem_rd_data (A) is captured at the end of this cycle. Next state is WAIT.
- WAIT: the last read's data is captured at the end of the cycle. Next state is WRITE.
- WRITE: mem_wr_en=1, mem_wr_addr=addr_res+idx, mem_wr_data=result. Next state is NEXT.
- NEXT: all strobes low.
  - If idx is the last element: go to DONE.
  - Otherwise: idx+1, go to RD_A.
- DONE: done=1, busy=0. Hold until start=0, then return to IDLE (done=0 from the following cycle).
- Arithmetic (W=ELEMENT_WIDTH):
  - Mode 0: full W+SCALAR_WIDTH product. Overflow if any upper bit is set.
  - Mode 1: W+1-bit sum. Overflow on carry.
  - Mode 2: underflow if A<B.
  - Mode 3: A plus zero-extended s. Overflow on carry.
  - On overflow with SATURATE=1: result is all ones. On underflow with SATURATE=1: result is 0.
  - With SATURATE=0: low W bits.
  - Any overflow or underflow sets sat_flag regardless of SATURATE.
- In-place operation (addr_res equal to addr_op1) is legal: each element is read before its own write.

## Timing
- Memory read latency is 1: data is valid in the cycle after mem_rd_en=1.
- Reset values: state IDLE. busy, done, error, sat_flag, mem_rd_en and mem_wr_en are 0. Address and data outputs are 0.
- rst asserted in any state returns to IDLE at the next edge. No further strobes are issued after that edge.
- Cycle 0 is the cycle in which start is sampled in IDLE.
- Unary modes (0, 3):
  - Element k: RD_A in cycle 4k+1, WAIT in 4k+2, WRITE in 4k+3, NEXT in 4k+4.
  - done rises in cycle 4N+1, where N=dim_m*dim_n.
- Binary modes (1, 2):
  - Element k: RD_A in cycle 5k+1, RD_B in 5k+2, WAIT in 5k+3, WRITE in 5k+4, NEXT in 5k+5.
  - done rises in cycle 5N+1.
- Error path: done=1 and error=1 in cycle 1.
- Each strobe is exactly one cycle wide. Read and write strobes are never high in the same cycle.
- start held high through DONE does not retrigger. A new operation requires start to go low, then high again.

## Test plan
- Mode 0, 2x3, A=1..6, s=3, SATURATE=1 -> results 3,6,9,12,15,18 at addr_res..+5; done in cycle 25; sat_flag=0.
- Mode 1, 4x4, A[i]=0xFFF0, B[i]=0x20, SATURATE=1 -> all results 0xFFFF, sat_flag=1. Repeat with SATURATE=0 -> all 0x0010, sat_flag=1.
- Mode 2, 1x2, A={5,2}, B={3,7} -> {2,0}, sat_flag=1; done in cycle 11.
- dim_m=0, then dim_n=17 -> error=1 and done in cycle 1; zero mem_rd_en or mem_wr_en pulses.
- Mode 3, 16x16 in place, addr_op1=addr_res=500, ADDR_WIDTH=9 -> addresses wrap past 511 to 0..243. Every element increments by s. Exactly 256 writes.
- Reset asserted in cycle 7 of a mode-1 run -> strobes low from the next edge. A fresh start then completes correctly. start held high after done -> no second run.
